register_file_sb: RTL
=====================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock for all state.
REQ-002 SHALL have reset input 1: synchronous, active-high, sampled on posedge clk.
REQ-003 SHALL have ra_addr, rb_addr, rc_addr inputs [0:6]: source register addresses.
REQ-004 SHALL have ra, rb, rc outputs [0:127]: registered read data for the addresses sampled at the previous edge.
REQ-005 SHALL have rt_wb_even input [0:127], rt_addr_wb_even input [0:6], reg_write_wb_even input 1: even-pipe writeback port.
REQ-006 SHALL have rt_wb_odd input [0:127], rt_addr_wb_odd input [0:6], reg_write_wb_odd input 1: odd-pipe writeback port.
REQ-007 SHALL have issue_valid input 1: an instruction requests issue this cycle.
REQ-008 SHALL have issue_reg_write input 1: the issuing instruction will write a register.
REQ-009 SHALL have issue_rt_addr input [0:6]: destination address of the issuing instruction.
REQ-010 SHALL have issue_latency input [2:0]: writeback latency of the issuing instruction, in cycles.
REQ-011 SHALL have stall output 1: combinational; the issue is refused this cycle.

Function
REQ-012 SHALL hold 128 registers of 128 bits; register 0 is an ordinary register, not hardwired.
REQ-013 SHALL write rt_wb_even to register rt_addr_wb_even on posedge clk when reg_write_wb_even=1; the odd port behaves the same way.
REQ-014 SHALL commit only the odd-port data when both ports write the same address in the same cycle.
REQ-015 SHALL register each read port on posedge clk, giving read latency 1.
REQ-016 SHALL bypass same-cycle writeback data into a read port when that port's address matches an active writeback address; on a double match the odd data wins.
REQ-017 SHALL keep a 3-bit pending counter per register.
REQ-018 SHALL assert stall = issue_valid && (cnt[ra_addr]!=0 || cnt[rb_addr]!=0 || cnt[rc_addr]!=0 || (issue_reg_write && cnt[issue_rt_addr]!=0)).
REQ-019 SHALL treat the issue as accepted when issue_valid=1, stall=0 and issue_reg_write=1; on accept, cnt[issue_rt_addr] <= issue_latency.
REQ-020 SHALL decrement every other nonzero counter by 1 per cycle; no counter underflows below 0.
REQ-021 SHALL leave the accepted destination counter untouched by decrement in the accept cycle; the loaded value wins.
REQ-022 SHALL, on an accept with issue_latency=0, leave the counter at 0 so the register is untracked.
REQ-023 SHALL NOT let writeback ports alter the counters; pending status is purely time-based.
REQ-024 SHALL hold stall at 0 whenever issue_valid=0, whatever the counter state.

Reset
REQ-025 SHALL, on reset=1 at posedge clk, clear all 128 registers, all counters, and ra/rb/rc to 0.
REQ-026 SHALL drop an issue or writeback presented in a reset cycle; the reset result wins.
REQ-027 SHALL clear in-flight pending state on reset mid-operation; stall is 0 in the next cycle.

Verification
REQ-028 SHALL pass: write even addr 5 = 0x11..11 with reg_write_wb_even=1, next cycle ra_addr=5 -> ra=0x11..11 one edge later.
REQ-029 SHALL pass: even and odd both write addr 9 (0xAA.., 0xBB..) in one cycle, ra_addr=9 in that same cycle -> ra=0xBB.. after the edge (bypass), and a later read of 9 also returns 0xBB...
REQ-030 SHALL pass: accept issue rt=3 latency=4, next cycle issue with ra_addr=3 -> stall=1 for 4 cycles, then stall=0.
REQ-031 SHALL pass: issue rt=7 latency=2, immediately issue rt=7 again (WAW) -> stall=1 until cnt[7]=0.
REQ-032 SHALL pass: issue rt=3 latency=0 -> cnt[3] stays 0 and a dependent issue sees stall=0.
REQ-033 SHALL pass: load pending rt=12 latency=6, assert reset after 2 cycles -> stall=0 next cycle and ra=rb=rc=0.

Source files
------------

// File: rtl/register_file_sb.sv
// 128 x 128-bit register file with two writeback ports, same-cycle read bypass,
// and per-register pending counters that produce the issue stall.
module register_file_sb (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:6]   ra_addr,
  input  logic [0:6]   rb_addr,
  input  logic [0:6]   rc_addr,
  output logic [0:127] ra,
  output logic [0:127] rb,
  output logic [0:127] rc,
  input  logic [0:127] rt_wb_even,
  input  logic [0:6]   rt_addr_wb_even,
  input  logic         reg_write_wb_even,
  input  logic [0:127] rt_wb_odd,
  input  logic [0:6]   rt_addr_wb_odd,
  input  logic         reg_write_wb_odd,
  input  logic         issue_valid,
  input  logic         issue_reg_write,
  input  logic [0:6]   issue_rt_addr,
  input  logic [2:0]   issue_latency,
  output logic         stall
);

  localparam int unsigned DW   = 128;
  localparam int unsigned AW   = 7;
  localparam int unsigned NREG = 128;
  localparam int unsigned CW   = 3;

  logic [0:DW-1] regs [NREG];
  logic [CW-1:0] cnt  [NREG];
  logic [0:DW-1] ra_nxt_c, rb_nxt_c, rc_nxt_c;
  logic          accept_c;

  // Newest value for an address: stored data overridden by same-cycle writebacks, odd last.
  function automatic logic [0:DW-1] read_mux(input logic [0:AW-1] addr,
                                             input logic [0:DW-1] stored);
    read_mux = stored;
    if (reg_write_wb_even && (rt_addr_wb_even == addr)) read_mux = rt_wb_even;
    if (reg_write_wb_odd && (rt_addr_wb_odd == addr))   read_mux = rt_wb_odd;
  endfunction

  always_comb begin
    ra_nxt_c = read_mux(ra_addr, regs[ra_addr]);
    rb_nxt_c = read_mux(rb_addr, regs[rb_addr]);
    rc_nxt_c = read_mux(rc_addr, regs[rc_addr]);
  end

  // Stall when any source or (for writers) the destination is still pending.
  always_comb begin
    stall = 1'b0;
    if (issue_valid) begin
      stall = (cnt[ra_addr] != '0) || (cnt[rb_addr] != '0) || (cnt[rc_addr] != '0) ||
              (issue_reg_write && (cnt[issue_rt_addr] != '0));
    end
  end

  assign accept_c = issue_valid && !stall && issue_reg_write;

  // Register storage and registered read ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      ra <= '0;
      rb <= '0;
      rc <= '0;
    end else begin
      if (reg_write_wb_even) regs[rt_addr_wb_even] <= rt_wb_even;
      if (reg_write_wb_odd)  regs[rt_addr_wb_odd]  <= rt_wb_odd;
      ra <= ra_nxt_c;
      rb <= rb_nxt_c;
      rc <= rc_nxt_c;
    end
  end

  // Pending counters: time-based countdown, reloaded by an accepted issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (accept_c && (issue_rt_addr == AW'(i))) begin
          cnt[i] <= issue_latency;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

endmodule
